// File: rtl/load_stall_ctrl_if.sv
// Handshake bundle between the EX/MEM-side pipeline, the load sequencer and the data-memory port.
// Latency: none, this is wiring only.
// Backpressure: dm_gnt/dm_rvalid from memory; stall_hold back to the hazard controller.
interface load_stall_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic              dm_req;
   logic [ADDR_W-1:0] dm_addr;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   logic              stall_hold;
   logic [DATA_W-1:0] ld_data;
   logic              ld_data_valid;
   logic              ld_err;

   // Environment side: pipeline plus data memory
   modport master (
      output ld_req, ld_addr, dm_gnt, dm_rvalid, dm_rdata,
      input  dm_req, dm_addr, stall_hold, ld_data, ld_data_valid, ld_err
   );

   // Sequencer side
   modport slave (
      input  ld_req, ld_addr, dm_gnt, dm_rvalid, dm_rdata,
      output dm_req, dm_addr, stall_hold, ld_data, ld_data_valid, ld_err
   );
endinterface

// File: rtl/load_stall_ctrl.sv
// Multi-cycle data-memory load sequencer; freezes the pipeline until read data returns.
// Latency: stall = 1 + REQ cycles + WAIT cycles, then one DONE release cycle with ld_data valid.
// Backpressure: holds dm_req/dm_addr until dm_gnt; optional watchdog via LOAD_STALL_TIMEOUT_EN.
module load_stall_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input logic              clk,
   input logic              rst_n,
   load_stall_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q;
   logic              dm_req_q;
   logic [ADDR_W-1:0] dm_addr_q;
   logic [DATA_W-1:0] ld_data_q;
   logic              ld_data_valid_q;
   logic              data_hit;
   logic              tmo_hit;
   logic              busy;

   // A watchdog of zero cycles would make every load fail immediately
   if (TIMEOUT < 1) begin : g_tmo_chk
      $error("load_stall_ctrl: TIMEOUT must be at least 1");
   end

   // Read data is only accepted while the load is in flight; in REQ it must come with the grant
   assign data_hit = ((state_q == S_REQ)  && bus.dm_gnt && bus.dm_rvalid) ||
                     ((state_q == S_WAIT) && bus.dm_rvalid);

   assign busy = (state_q == S_REQ) || (state_q == S_WAIT);

`ifdef LOAD_STALL_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] tmo_cnt_q;
   logic [CNT_W-1:0] tmo_cnt_d;
   logic             ld_err_q;

   // Counter value including the current REQ/WAIT cycle; data arriving in that cycle beats the timeout
   assign tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
   assign tmo_hit   = busy && (tmo_cnt_d == TMO_VAL) && !data_hit;

   // Watchdog counter, cleared on entry to REQ, counting every REQ/WAIT cycle; sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
         ld_err_q  <= 1'b0;
      end else begin
         if ((state_q == S_IDLE) && bus.ld_req) begin
            tmo_cnt_q <= '0;
         end else if (busy) begin
            tmo_cnt_q <= tmo_cnt_d;
         end
         if (tmo_hit) begin
            ld_err_q <= 1'b1;
         end
      end
   end

   assign bus.ld_err = ld_err_q;
`else
   assign tmo_hit    = 1'b0;
   assign bus.ld_err = 1'b0;
`endif

   // Load sequencing FSM with registered memory-side and MEM/WB-side outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         dm_req_q        <= 1'b0;
         dm_addr_q       <= '0;
         ld_data_q       <= '0;
         ld_data_valid_q <= 1'b0;
      end else begin
         ld_data_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.ld_req) begin
                  state_q   <= S_REQ;
                  dm_req_q  <= 1'b1;
                  dm_addr_q <= bus.ld_addr;
               end
            end
            S_REQ: begin
               if (data_hit) begin
                  state_q         <= S_DONE;
                  dm_req_q        <= 1'b0;
                  ld_data_q       <= bus.dm_rdata;
                  ld_data_valid_q <= 1'b1;
               end else if (tmo_hit) begin
                  state_q         <= S_DONE;
                  dm_req_q        <= 1'b0;
                  ld_data_q       <= '0;
                  ld_data_valid_q <= 1'b1;
               end else if (bus.dm_gnt) begin
                  state_q  <= S_WAIT;
                  dm_req_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (data_hit) begin
                  state_q         <= S_DONE;
                  ld_data_q       <= bus.dm_rdata;
                  ld_data_valid_q <= 1'b1;
               end else if (tmo_hit) begin
                  state_q         <= S_DONE;
                  ld_data_q       <= '0;
                  ld_data_valid_q <= 1'b1;
               end
            end
            S_DONE: begin
               // The same load is still sitting in ID/EX here, so ld_req must not restart it
               state_q <= S_IDLE;
            end
            default: begin
               state_q  <= S_IDLE;
               dm_req_q <= 1'b0;
            end
         endcase
      end
   end

   // Mealy in IDLE so the pipeline freezes in the same cycle the load shows up; Moore elsewhere
   assign bus.stall_hold    = (state_q == S_IDLE) ? bus.ld_req : (state_q != S_DONE);
   assign bus.dm_req        = dm_req_q;
   assign bus.dm_addr       = dm_addr_q;
   assign bus.ld_data       = ld_data_q;
   assign bus.ld_data_valid = ld_data_valid_q;

endmodule

// File: tb/tb_load_stall_ctrl.sv
// Self-checking bench for load_stall_ctrl: directed scenarios plus randomized load timelines.
// Latency: expected timeline per load computed from grant/read delays.
// Backpressure: memory grant and read-valid delays randomized; rvalid noise where it must be ignored.
module tb_load_stall_ctrl;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 15;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   load_stall_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   load_stall_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            checks = 0;
   int            errors = 0;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_data;
   logic          exp_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic req, input logic [AW-1:0] addr, input logic gnt,
                        input logic rv, input logic [DW-1:0] rd);
      bus.ld_req    = req;
      bus.ld_addr   = addr;
      bus.dm_gnt    = gnt;
      bus.dm_rvalid = rv;
      bus.dm_rdata  = rd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One cycle with no load pending; nothing may move and held values must persist
   task automatic idle_cycle();
      drive(1'b0, $urandom, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      @(negedge clk);
      chk("idle stall_hold", bus.stall_hold, 1'b0);
      chk("idle dm_req", bus.dm_req, 1'b0);
      chk("idle ld_data_valid", bus.ld_data_valid, 1'b0);
      chk("idle dm_addr", bus.dm_addr, last_addr);
      chk("idle ld_data", bus.ld_data, last_data);
      chk("idle ld_err", bus.ld_err, exp_err);
      next_cycle();
   endtask

   // One complete load: cycle 0 is the IDLE cycle that sees ld_req, grant arrives in
   // REQ cycle g, read data w cycles later (w=0: together with the grant), then DONE.
   // With tmo set, no data ever comes and DONE follows the last watchdog cycle.
   task automatic run_load(input logic [AW-1:0] addr, input int g, input int w,
                           input logic [DW-1:0] data, input bit tmo);
      int            done_k;
      logic [DW-1:0] exp_d;
      done_k = g + w + 1;
      exp_d  = tmo ? '0 : data;
      for (int k = 0; k <= done_k; k++) begin
         logic          gnt;
         logic          rv;
         logic [DW-1:0] rd;
         gnt = (k == g);
         rd  = $urandom;
         if (k < g) begin
            rv = 1'($urandom_range(0, 1));
         end else if (k == done_k) begin
            rv = 1'($urandom_range(0, 1));
         end else if (!tmo && (k == g + w)) begin
            rv = 1'b1;
            rd = data;
         end else begin
            rv = 1'b0;
         end
         drive(1'b1, addr, gnt, rv, rd);
         @(negedge clk);
         chk("stall_hold", bus.stall_hold, k < done_k);
         chk("dm_req", bus.dm_req, (k >= 1) && (k <= g));
         chk("dm_addr", bus.dm_addr, (k == 0) ? last_addr : addr);
         chk("ld_data_valid", bus.ld_data_valid, k == done_k);
         chk("ld_data", bus.ld_data, (k == done_k) ? exp_d : last_data);
         if (tmo && (k == done_k)) exp_err = 1'b1;
         chk("ld_err", bus.ld_err, exp_err);
         next_cycle();
      end
      last_addr = addr;
      last_data = exp_d;
   endtask

   initial begin
      last_addr = '0;
      last_data = '0;
      exp_err   = 1'b0;

      // Reset values
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("rst stall_hold", bus.stall_hold, 1'b0);
      chk("rst dm_req", bus.dm_req, 1'b0);
      chk("rst dm_addr", bus.dm_addr, 32'h0);
      chk("rst ld_data", bus.ld_data, 32'h0);
      chk("rst ld_data_valid", bus.ld_data_valid, 1'b0);
      chk("rst ld_err", bus.ld_err, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycle();

      // Zero-wait load
      run_load(32'h100, 1, 0, 32'hDEADBEEF, 1'b0);
      idle_cycle();

      // Grant in the third REQ cycle, data after three WAIT cycles: 7 stall cycles
      run_load(32'h200, 3, 3, 32'h1234_5678, 1'b0);

      // Back-to-back loads with ld_req held through DONE
      run_load(32'h10, 1, 0, 32'hAAAA_0010, 1'b0);
      run_load(32'h14, 1, 1, 32'hBBBB_0014, 1'b0);
      idle_cycle();

      // Reset in the middle of WAIT, then a late read-valid that must be dropped
      drive(1'b1, 32'h300, 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("mr idle stall_hold", bus.stall_hold, 1'b1);
      next_cycle();
      drive(1'b1, 32'h300, 1'b1, 1'b0, '0);
      @(negedge clk);
      chk("mr req dm_req", bus.dm_req, 1'b1);
      chk("mr req dm_addr", bus.dm_addr, 32'h300);
      next_cycle();
      drive(1'b1, 32'h300, 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("mr wait stall_hold", bus.stall_hold, 1'b1);
      chk("mr wait dm_req", bus.dm_req, 1'b0);
      next_cycle();
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("mr rst stall_hold", bus.stall_hold, 1'b0);
      chk("mr rst dm_addr", bus.dm_addr, 32'h0);
      next_cycle();
      rst_n = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b1, 32'h55);
      @(negedge clk);
      chk("mr late stall_hold", bus.stall_hold, 1'b0);
      chk("mr late ld_data_valid", bus.ld_data_valid, 1'b0);
      next_cycle();
      last_addr = '0;
      last_data = '0;
      exp_err   = 1'b0;
      idle_cycle();

      // Data arriving in the 15th REQ+WAIT cycle completes normally
      run_load(32'h400, 1, TMO - 1, 32'h0000_00A5, 1'b0);
      idle_cycle();

`ifdef LOAD_STALL_TIMEOUT_EN
      // Watchdog expiry: no read data ever returns
      run_load(32'h500, 3, TMO - 3, 32'hFFFF_FFFF, 1'b1);
      idle_cycle();
      // Error flag stays set across later good loads
      run_load(32'h504, 2, 1, 32'hCAFE_F00D, 1'b0);
      idle_cycle();
`endif

      // Randomized load timelines with random idle gaps
      for (int n = 0; n < 40; n++) begin
         int gap;
         run_load($urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
                  $urandom, 1'b0);
         gap = int'($urandom_range(0, 2));
         for (int i = 0; i < gap; i++) idle_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
